traffic_phase_sched: RTL and testbench
======================================

# traffic_phase_sched

Actuated four-approach intersection controller. Replaces the fixed 32-slot time wheel with a scheduler that serves vehicle-sensor requests in round-robin order. Green times are bounded by minimum and maximum limits, and yellow and all-red clearance intervals are inserted between phases. An emergency-vehicle preempt forces the intersection to a chosen approach. It drives the same per-approach red/yellow/green lamp lines as the existing signal top level.

## Interface
Parameters:
- MIN_GREEN, default 4: minimum green length in cycles (≥1).
- MAX_GREEN, default 12: maximum green length in cycles with no emergency (≥ MIN_GREEN).
- YELLOW, default 2: yellow length in cycles (≥1).
- ALL_RED, default 1: all-red clearance length in cycles (≥1).
- CNT_W, default 4: timer width. Must hold MAX_GREEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset. Synchronous and active-low.
- veh_req  in  4  vehicle presence per approach. Level input, sampled every clk.
- emerg_req  in  1  emergency preempt request. Level input.
- emerg_dir  in  2  approach index to preempt to. Only meaningful while emerg_req=1.
- g  out  4  green lamp per approach. At most one bit set.
- y  out  4  yellow lamp per approach. At most one bit set.
- r  out  4  red lamp per approach, equal to ~(g|y).
- phase  out  2  index of the approach currently served or last served.
- emerg_act  out  1  high while a preempt green is being held.

## Operation
- FSM states: CLEAR (all red), GREEN, YELLOW. All outputs are registered.
- Reset values: state=CLEAR, timer=1, phase=0, pending=0, g=0, y=0, r=4'b1111, emerg_act=0.
- pending[3:0] holds sticky request latches:
  - bit i sets when veh_req[i]=1, except while approach i is GREEN.
  - bit i clears on the cycle approach i enters GREEN. Clear wins over a simultaneous set.
- CLEAR lasts ALL_RED cycles, then GREEN begins on the selected approach. Selection rules, in priority order:
  1. If emerg_req=1, select emerg_dir.
  2. Otherwise, round-robin over pending in search order phase+1, phase+2, phase+3, then phase (mod 4).
  3. If nothing is pending, select phase+1, so an idle intersection keeps cycling.
- GREEN on approach p. Count timer t from 1 on the first green cycle. The phase ends after cycle t when the first true condition is:
  - (a) emerg_req=1 and emerg_dir≠p: ends immediately. MIN_GREEN is ignored.
  - (b) emerg_req=1 and emerg_dir=p: green is held with no limit. emerg_act=1. The timer saturates at MAX_GREEN.
  - (c) t ≥ MIN_GREEN and pending has any bit other than p set. This is gap-out.
  - (d) t = MAX_GREEN. This is max-out.
- When emerg_req drops during a held green, rules (c) and (d) resume using the saturated t. The phase therefore ends on the next cycle unless MIN_GREEN has not yet been reached.
- YELLOW lasts YELLOW cycles on approach p, then goes to CLEAR. An emergency request arriving during YELLOW or CLEAR does not shorten them. It affects only the next selection.
- The phase output updates on entry to GREEN.

## Timing
- Each state occupies exactly its programmed count of consecutive cycles. State and lamp outputs change together on the same clk edge.
- Request latency: veh_req sampled high at edge k makes pending visible at edge k+1. A gap-out decision uses pending as registered.
- Emergency latency: emerg_req sampled at edge k during a conflicting GREEN puts y on that approach from edge k+1.
- Full cycle per served phase: green length + YELLOW + ALL_RED. With defaults and idle inputs this is 12+2+1 = 15 cycles.
- Reset asserted mid-operation forces all reset values on the next edge. The first green (approach 0 if idle) appears ALL_RED cycles after rst_n is released.
- Invariant checked every cycle: popcount(g|y) ≤ 1, and g&y = 0.

## Structure
- Shared package traffic_pkg holds:
  - state enum {CLEAR, GREEN, YELLOW}
  - approach index type (2 bits)
  - lamp-vector helpers
- The four timing parameters are not in the package. They stay as module parameters.
- One natural sub-module: rr_pick4. It is a combinational round-robin picker that takes pending[3:0] and last[1:0] and returns a grant index and a valid flag.
- The FSM, timer, pending latches and output registers live in traffic_phase_sched.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles, then release with no requests -> r=1111 for 1 cycle, g=0001 for 12 cycles, y=0001 for 2, r=1111 for 1, then g=0010.
- Gap-out skip: veh_req[2] pulsed on green cycle 1 of approach 0 -> g=0001 lasts exactly 4 cycles, then yellow 2, clear 1, then g=0100 (approach 1 skipped), and pending[2] clears.
- Fairness: veh_req=4'b1111 held -> greens go 0,1,2,3,0…, each exactly 4 cycles, period 28 cycles.
- Preempt: emerg_req=1, emerg_dir=3 on approach 0 green cycle 2 -> y=0001 next cycle, then clear, then g=1000 with emerg_act=1 held for 20 cycles while the request stays high. After the request drops with veh_req[1] pending, yellow follows next cycle.
- Self re-serve: only veh_req[0] is pulsed, during approach 0's yellow -> the next green is approach 0 again.
- Mid-operation reset: rst_n=0 during YELLOW -> next edge g=0, y=0, r=1111, phase=0, pending=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and lamp helpers for the actuated four-approach signal controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  typedef logic [1:0] appr_t;

  localparam int unsigned N_APPR = 4;

  function automatic logic [3:0] lamp_onehot(input appr_t a);
    return 4'b0001 << a;
  endfunction

  function automatic logic [3:0] lamp_red(input logic [3:0] gv, input logic [3:0] yv);
    return ~(gv | yv);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, then last.
// With nothing pending it proposes last+1 and deasserts valid.
module rr_pick4
  import traffic_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  appr_t cand;

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    grant = last + 2'd1;
    valid = 1'b0;
    cand  = 2'd0;
    for (int k = N_APPR; k >= 1; k--) begin
      cand  = last + k[1:0];
      grant = pending[cand] ? cand : grant;
      valid = valid | pending[cand];
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Actuated intersection scheduler: min/max green, yellow and all-red clearance,
// round-robin service of sticky vehicle requests and emergency preempt.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW    = 2,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] veh_req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [3:0] g,
  output logic [3:0] y,
  output logic [3:0] r,
  output logic [1:0] phase,
  output logic       emerg_act
);

  localparam logic [CNT_W-1:0] ONE_T = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALL_RED);

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  appr_t            phase_nx;
  logic [3:0]       pending, pending_nx;
  logic             first, first_nx;
  logic             act_nx, enter;
  logic [3:0]       g_nx, y_nx, green_mask, others;
  appr_t            last_pick, pick_grant, sel;
  logic             pick_valid;

  // Before any phase has been served, search starts at approach 0.
  assign last_pick  = first ? 2'd3 : phase;
  assign sel        = emerg_req ? emerg_dir : (pick_valid ? pick_grant : last_pick + 2'd1);
  assign green_mask = (state == ST_GREEN) ? lamp_onehot(phase) : 4'b0000;
  assign others     = pending & ~lamp_onehot(phase);

  rr_pick4 u_pick (
    .pending (pending),
    .last    (last_pick),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  // Next-state, timer and request-latch decisions.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    phase_nx = phase;
    first_nx = first;
    act_nx   = 1'b0;
    enter    = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (timer >= AR_T) begin
          state_nx = ST_GREEN;
          timer_nx = ONE_T;
          phase_nx = sel;
          first_nx = 1'b0;
          enter    = 1'b1;
          act_nx   = emerg_req;
        end else begin
          timer_nx = timer + ONE_T;
        end
      end
      ST_GREEN: begin
        if (emerg_req && (emerg_dir != phase)) begin
          state_nx = ST_YELLOW;
          timer_nx = ONE_T;
        end else if (emerg_req) begin
          // Held preempt green: timer parks at MAX so release ends it promptly.
          act_nx   = 1'b1;
          timer_nx = (timer >= MAX_T) ? MAX_T : timer + ONE_T;
        end else if (((timer >= MIN_T) && (|others)) || (timer >= MAX_T)) begin
          state_nx = ST_YELLOW;
          timer_nx = ONE_T;
        end else begin
          timer_nx = timer + ONE_T;
        end
      end
      ST_YELLOW: begin
        if (timer >= YEL_T) begin
          state_nx = ST_CLEAR;
          timer_nx = ONE_T;
        end else begin
          timer_nx = timer + ONE_T;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        timer_nx = ONE_T;
      end
    endcase
    pending_nx = (pending | (veh_req & ~green_mask)) & ~(enter ? lamp_onehot(sel) : 4'b0000);
    g_nx = (state_nx == ST_GREEN)  ? lamp_onehot(phase_nx) : 4'b0000;
    y_nx = (state_nx == ST_YELLOW) ? lamp_onehot(phase_nx) : 4'b0000;
  end

  // State, latches and lamp registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      timer     <= ONE_T;
      phase     <= 2'd0;
      pending   <= 4'b0000;
      first     <= 1'b1;
      g         <= 4'b0000;
      y         <= 4'b0000;
      r         <= 4'b1111;
      emerg_act <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      phase     <= phase_nx;
      pending   <= pending_nx;
      first     <= first_nx;
      g         <= g_nx;
      y         <= y_nx;
      r         <= lamp_red(g_nx, y_nx);
      emerg_act <= act_nx;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed self-checking bench for traffic_phase_sched with default timing.
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] veh_req = 4'b0000;
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_dir = 2'd0;
  logic [3:0] g, y, r;
  logic [1:0] phase;
  logic       emerg_act;
  logic [3:0] oh;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_phase_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .veh_req   (veh_req),
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
    .g         (g),
    .y         (y),
    .r         (r),
    .phase     (phase),
    .emerg_act (emerg_act)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lamps(input string tag, input logic [3:0] eg, input logic [3:0] ey);
    logic [3:0] er;
    er = ~(eg | ey);
    chk({tag, ".g"}, 32'(g), 32'(eg));
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".r"}, 32'(r), 32'(er));
  endtask

  task automatic do_reset();
    veh_req   = 4'b0000;
    emerg_req = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and idle cycling
    do_reset();
    lamps("rst", 4'b0000, 4'b0000);
    chk("rst.phase", 32'(phase), 32'd0);
    chk("rst.act", 32'(emerg_act), 32'd0);
    chk("rst.pending", 32'(dut.pending), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      lamps("idle.g0", 4'b0001, 4'b0000);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      lamps("idle.y0", 4'b0000, 4'b0001);
    end
    tick();
    lamps("idle.clr", 4'b0000, 4'b0000);
    tick();
    lamps("idle.g1", 4'b0010, 4'b0000);
    chk("idle.phase", 32'(phase), 32'd1);

    // Gap-out skipping approach 1
    do_reset();
    tick();
    lamps("gap.g0c1", 4'b0001, 4'b0000);
    veh_req = 4'b0100;
    tick();
    veh_req = 4'b0000;
    lamps("gap.g0c2", 4'b0001, 4'b0000);
    chk("gap.pend", 32'(dut.pending), 32'h4);
    tick();
    lamps("gap.g0c3", 4'b0001, 4'b0000);
    tick();
    lamps("gap.g0c4", 4'b0001, 4'b0000);
    tick();
    lamps("gap.y0a", 4'b0000, 4'b0001);
    tick();
    lamps("gap.y0b", 4'b0000, 4'b0001);
    tick();
    lamps("gap.clr", 4'b0000, 4'b0000);
    tick();
    lamps("gap.g2", 4'b0100, 4'b0000);
    chk("gap.phase", 32'(phase), 32'd2);
    chk("gap.pendclr", 32'(dut.pending), 32'd0);

    // Fairness with all approaches requesting
    do_reset();
    veh_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      for (int i = 0; i < 4; i++) begin
        tick();
        lamps("fair.g", oh, 4'b0000);
      end
      chk("fair.phase", 32'(phase), 32'(k % 4));
      for (int i = 0; i < 2; i++) begin
        tick();
        lamps("fair.y", 4'b0000, oh);
      end
      tick();
      lamps("fair.clr", 4'b0000, 4'b0000);
    end

    // Emergency preempt to approach 3
    do_reset();
    tick();
    lamps("emg.g0c1", 4'b0001, 4'b0000);
    tick();
    lamps("emg.g0c2", 4'b0001, 4'b0000);
    emerg_req = 1'b1;
    emerg_dir = 2'd3;
    tick();
    lamps("emg.y0a", 4'b0000, 4'b0001);
    chk("emg.act_y", 32'(emerg_act), 32'd0);
    tick();
    lamps("emg.y0b", 4'b0000, 4'b0001);
    tick();
    lamps("emg.clr", 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      lamps("emg.hold", 4'b1000, 4'b0000);
      chk("emg.act", 32'(emerg_act), 32'd1);
      veh_req = (i == 5) ? 4'b0010 : 4'b0000;
    end
    chk("emg.pend", 32'(dut.pending), 32'h2);
    chk("emg.phase", 32'(phase), 32'd3);
    emerg_req = 1'b0;
    tick();
    lamps("emg.y3", 4'b0000, 4'b1000);
    chk("emg.act_off", 32'(emerg_act), 32'd0);
    tick();
    tick();
    lamps("emg.clr2", 4'b0000, 4'b0000);
    tick();
    lamps("emg.g1", 4'b0010, 4'b0000);
    chk("emg.phase1", 32'(phase), 32'd1);

    // Self re-serve of approach 0
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    tick();
    lamps("self.y0a", 4'b0000, 4'b0001);
    veh_req = 4'b0001;
    tick();
    veh_req = 4'b0000;
    lamps("self.y0b", 4'b0000, 4'b0001);
    chk("self.pend", 32'(dut.pending), 32'h1);
    tick();
    lamps("self.clr", 4'b0000, 4'b0000);
    tick();
    lamps("self.g0", 4'b0001, 4'b0000);
    chk("self.phase", 32'(phase), 32'd0);
    chk("self.pendclr", 32'(dut.pending), 32'd0);

    // Reset asserted during yellow of approach 1
    do_reset();
    for (int i = 0; i < 27; i++) tick();
    tick();
    lamps("mid.y1", 4'b0000, 4'b0010);
    chk("mid.phase1", 32'(phase), 32'd1);
    veh_req = 4'b1001;
    tick();
    chk("mid.pend", 32'(dut.pending), 32'h9);
    rst_n = 1'b0;
    tick();
    lamps("mid.rst", 4'b0000, 4'b0000);
    chk("mid.phase0", 32'(phase), 32'd0);
    chk("mid.pend0", 32'(dut.pending), 32'd0);
    chk("mid.act", 32'(emerg_act), 32'd0);
    veh_req = 4'b0000;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
